// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite RAM writer slice.
package sprite_pkg;

  typedef logic [23:0] pixel_t;
  typedef logic [12:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } writer_state_t;

  localparam int unsigned SPRITE_DIM   = 40;
  localparam int unsigned SPRITE_WORDS = 1600;

endpackage

// File: rtl/sprite_ram_writer_if.sv
// Pixel stream handshake plus registered RAM write port of the sprite writer.
interface sprite_ram_writer_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 13
);

  logic [DATA_W-1:0] pixel_in;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              we;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport master (
    output pixel_in,
    output pixel_valid,
    input  pixel_ready,
    input  we,
    input  write_address,
    input  write_data
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    output pixel_ready,
    output we,
    output write_address,
    output write_data
  );

endinterface

// File: rtl/sprite_addr_gen.sv
// Column/row walker for a rectangular window inside a flat RAM, with range check.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned MEM_DEPTH = SPRITE_WORDS,
  parameter int unsigned SPRITE_W  = SPRITE_DIM,
  parameter int unsigned SPRITE_H  = SPRITE_DIM,
  parameter int unsigned STRIDE    = SPRITE_DIM
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_address,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range,
  output logic              last
);

  localparam int unsigned COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] base_q;
  logic [SUM_W-1:0]  sum;
  logic              col_last;
  logic              row_last;

  assign col_last = (col_q == COL_W'(SPRITE_W - 1));
  assign row_last = (row_q == ROW_W'(SPRITE_H - 1));
  assign last     = col_last && row_last;

  // One extra bit so a window running past the top of the address space
  // is seen as out of range instead of wrapping back to low addresses.
  assign sum      = SUM_W'(base_q) + SUM_W'(32'(row_q) * STRIDE) + SUM_W'(col_q);
  assign addr     = sum[ADDR_W-1:0];
  assign in_range = (sum < SUM_W'(MEM_DEPTH));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      base_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (clear) begin
      base_q <= base_address;
      col_q  <= '0;
      row_q  <= '0;
    end else if (advance) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_ram_writer.sv
// Streams RGB pixels into a window of a flat sprite RAM through a registered write port.
// Optional SPRITE_RAM_WRITER_TRANSPARENT_SKIP_EN: pixels equal to KEY_COLOR are consumed but not written.
module sprite_ram_writer
  import sprite_pkg::*;
#(
  parameter int unsigned       DATA_W    = 24,
  parameter int unsigned       ADDR_W    = 13,
  parameter int unsigned       MEM_DEPTH = SPRITE_WORDS,
  parameter int unsigned       SPRITE_W  = SPRITE_DIM,
  parameter int unsigned       SPRITE_H  = SPRITE_DIM,
  parameter int unsigned       STRIDE    = SPRITE_DIM,
  parameter logic [DATA_W-1:0] KEY_COLOR = DATA_W'(24'hFF00FF)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_address,
  sprite_ram_writer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

`ifdef SPRITE_RAM_WRITER_TRANSPARENT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  writer_state_t     state_q, state_d;
  logic              xfer;
  logic              clear;
  logic              last;
  logic              in_range;
  logic              key_hit;
  logic              write_ok;
  logic [ADDR_W-1:0] addr;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;

  sprite_addr_gen #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .SPRITE_W  (SPRITE_W),
    .SPRITE_H  (SPRITE_H),
    .STRIDE    (STRIDE)
  ) u_addr_gen (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .clear        (clear),
    .advance      (xfer),
    .base_address (base_address),
    .addr         (addr),
    .in_range     (in_range),
    .last         (last)
  );

  assign xfer     = bus.pixel_valid && (state_q == WRITE);
  assign key_hit  = (bus.pixel_in == KEY_COLOR);
  assign write_ok = in_range && !(SKIP_EN && key_hit);

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          clear   = 1'b1;
        end
      end
      WRITE: begin
        if (xfer && last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Clipped or keyed pixels still update address/data; only we is suppressed.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      overflow <= 1'b0;
    end else begin
      we_q <= xfer && write_ok;
      if (xfer) begin
        wa_q <= addr;
        wd_q <= bus.pixel_in;
      end
      if (clear)                  overflow <= 1'b0;
      else if (xfer && !in_range) overflow <= 1'b1;
    end
  end

  assign bus.pixel_ready   = (state_q == WRITE);
  assign bus.we            = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Scoreboard bench for sprite_ram_writer: default 40x40 instance and a 4x2 window instance.
module tb_sprite_ram_writer;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned MEM_DEPTH = 1600;
  localparam int unsigned W0 = 40, H0 = 40, S0 = 40;
  localparam int unsigned W1 = 4,  H1 = 2,  S1 = 40;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam logic [23:0] ALT = 24'h00FF00;

`ifdef SPRITE_RAM_WRITER_TRANSPARENT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [12:0] base0 = '0, base1 = '0;
  logic        busy0, done0, ovf0;
  logic        busy1, done1, ovf1;

  sprite_ram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  sprite_ram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  sprite_ram_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
    .SPRITE_W(W0), .SPRITE_H(H0), .STRIDE(S0), .KEY_COLOR(KEY)
  ) u0 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start0), .base_address(base0),
    .bus(bus0), .busy(busy0), .done(done0), .overflow(ovf0)
  );

  sprite_ram_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
    .SPRITE_W(W1), .SPRITE_H(H1), .STRIDE(S1), .KEY_COLOR(KEY)
  ) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start1), .base_address(base1),
    .bus(bus1), .busy(busy1), .done(done1), .overflow(ovf1)
  );

  always #5 Clk = ~Clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned writes0 = 0, writes1 = 0;
  int unsigned done_cnt0 = 0, done_cnt1 = 0;
  int unsigned busy_low = 0;
  logic [12:0] done_addr0 = '0, done_addr1 = '0;
  logic        done_we0 = 1'b0, done_we1 = 1'b0;
  logic [36:0] sb0[$];
  logic [36:0] sb1[$];
  logic [36:0] e0, e1;

  // Scoreboard consumers: every write must match the oldest expected pair.
  always @(negedge Clk) begin
    if (bus0.we === 1'b1) begin
      writes0++;
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL u0_unexpected_write got addr=%0d data=%h required no write",
                 bus0.write_address, bus0.write_data);
      end else begin
        e0 = sb0.pop_front();
        if ({bus0.write_address, bus0.write_data} !== e0) begin
          errors++;
          $display("FAIL u0_write got addr=%0d data=%h required addr=%0d data=%h",
                   bus0.write_address, bus0.write_data, e0[36:24], e0[23:0]);
        end
      end
    end
    if (done0 === 1'b1) begin
      done_cnt0++;
      done_addr0 = bus0.write_address;
      done_we0   = bus0.we;
    end
    if (bus1.we === 1'b1) begin
      writes1++;
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_write got addr=%0d data=%h required no write",
                 bus1.write_address, bus1.write_data);
      end else begin
        e1 = sb1.pop_front();
        if ({bus1.write_address, bus1.write_data} !== e1) begin
          errors++;
          $display("FAIL u1_write got addr=%0d data=%h required addr=%0d data=%h",
                   bus1.write_address, bus1.write_data, e1[36:24], e1[23:0]);
        end
      end
    end
    if (done1 === 1'b1) begin
      done_cnt1++;
      done_addr1 = bus1.write_address;
      done_we1   = bus1.we;
    end
  end

  // Stimulus driver: streams pixels k0..k0+npix-1 and queues the writes they should cause.
  task automatic stream(input bit which, input bit do_start, input logic [12:0] base,
                        input int unsigned k0, input int unsigned npix,
                        input bit gap, input bit alt_key, output bit timed_out);
    int unsigned k, cyc, w, s, a;
    bit          vph;
    logic [23:0] pix;
    logic        v, rdy, bsy;
    k = k0; cyc = 0; vph = 1'b1; timed_out = 1'b0;
    w = which ? W1 : W0;
    s = which ? S1 : S0;
    busy_low = 0;
    if (do_start) begin
      @(posedge Clk); #1;
      if (which) begin start1 = 1'b1; base1 = base; end
      else       begin start0 = 1'b1; base0 = base; end
      @(posedge Clk); #1;
      start0 = 1'b0; start1 = 1'b0;
    end
    while (k < k0 + npix && !timed_out) begin
      pix = alt_key ? (k[0] ? ALT : KEY) : 24'(k);
      v   = gap ? vph : 1'b1;
      if (which) begin bus1.pixel_in = pix; bus1.pixel_valid = v; end
      else       begin bus0.pixel_in = pix; bus0.pixel_valid = v; end
      @(negedge Clk);
      rdy = which ? bus1.pixel_ready : bus0.pixel_ready;
      bsy = which ? busy1 : busy0;
      if (bsy !== 1'b1) busy_low++;
      if (v && rdy === 1'b1) begin
        a = 32'(base) + (k / w) * s + (k % w);
        if (a < MEM_DEPTH && !(SKIP && pix == KEY)) begin
          if (which) sb1.push_back({a[12:0], pix});
          else       sb0.push_back({a[12:0], pix});
        end
        k++;
      end
      @(posedge Clk); #1;
      vph = !vph;
      cyc++;
      if (cyc > 4 * npix + 20) timed_out = 1'b1;
    end
    bus0.pixel_valid = 1'b0;
    bus1.pixel_valid = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({bus0.we, bus0.pixel_ready, busy0, done0, ovf0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got we/rdy/busy/done/ovf=%b required 00000",
               {bus0.we, bus0.pixel_ready, busy0, done0, ovf0});
    end
    checks++;
    if (bus0.write_address !== 13'd0 || bus0.write_data !== 24'd0) begin
      errors++;
      $display("FAIL reset_port got addr=%0d data=%h required 0/0",
               bus0.write_address, bus0.write_data);
    end
    checks++;
    if ({bus1.we, bus1.pixel_ready, busy1, done1, ovf1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_u1 got %b required 00000",
               {bus1.we, bus1.pixel_ready, busy1, done1, ovf1});
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_full_fill;
    int unsigned wr, dc;
    bit to;
    wr = writes0; dc = done_cnt0;
    stream(1'b0, 1'b1, 13'd0, 0, 1600, 1'b0, 1'b0, to);
    repeat (3) @(negedge Clk);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout got timeout required 1600 transfers"); end
    checks++;
    if (writes0 - wr != 1600) begin
      errors++; $display("FAIL full_writes got %0d required 1600", writes0 - wr);
    end
    checks++;
    if (done_cnt0 - dc != 1) begin
      errors++; $display("FAIL full_done got %0d pulses required 1", done_cnt0 - dc);
    end
    checks++;
    if (done_addr0 !== 13'd1599 || done_we0 !== 1'b1) begin
      errors++;
      $display("FAIL full_last got addr=%0d we=%b required addr=1599 we=1", done_addr0, done_we0);
    end
    checks++;
    if (ovf0 !== 1'b0 || sb0.size() != 0) begin
      errors++;
      $display("FAIL full_end got ovf=%b pending=%0d required ovf=0 pending=0", ovf0, sb0.size());
    end
  endtask

  task automatic test_gaps;
    int unsigned wr, dc;
    bit to;
    wr = writes0; dc = done_cnt0;
    stream(1'b0, 1'b1, 13'd0, 0, 1600, 1'b1, 1'b0, to);
    repeat (3) @(negedge Clk);
    checks++;
    if (to || writes0 - wr != 1600) begin
      errors++; $display("FAIL gap_writes got %0d timeout=%b required 1600", writes0 - wr, to);
    end
    checks++;
    if (busy_low != 0) begin
      errors++; $display("FAIL gap_busy got %0d low cycles required 0", busy_low);
    end
    checks++;
    if (done_cnt0 - dc != 1 || sb0.size() != 0) begin
      errors++;
      $display("FAIL gap_done got done=%0d pending=%0d required 1/0", done_cnt0 - dc, sb0.size());
    end
  endtask

  task automatic test_small_window;
    int unsigned wr, dc;
    bit to;
    wr = writes1; dc = done_cnt1;
    stream(1'b1, 1'b1, 13'd100, 0, 8, 1'b0, 1'b0, to);
    repeat (3) @(negedge Clk);
    checks++;
    if (to || writes1 - wr != 8) begin
      errors++; $display("FAIL small_writes got %0d timeout=%b required 8", writes1 - wr, to);
    end
    checks++;
    if (done_cnt1 - dc != 1 || done_addr1 !== 13'd143 || done_we1 !== 1'b1) begin
      errors++;
      $display("FAIL small_done got done=%0d addr=%0d we=%b required 1/143/1",
               done_cnt1 - dc, done_addr1, done_we1);
    end
    checks++;
    if (sb1.size() != 0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL small_end got pending=%0d busy=%b required 0/0", sb1.size(), busy1);
    end
  endtask

  task automatic test_clip;
    int unsigned wr, dc;
    bit to;
    wr = writes0; dc = done_cnt0;
    stream(1'b0, 1'b1, 13'd1590, 0, 1600, 1'b0, 1'b0, to);
    repeat (3) @(negedge Clk);
    checks++;
    if (to || writes0 - wr != 10) begin
      errors++; $display("FAIL clip_writes got %0d timeout=%b required 10", writes0 - wr, to);
    end
    checks++;
    if (done_cnt0 - dc != 1 || done_we0 !== 1'b0) begin
      errors++;
      $display("FAIL clip_done got done=%0d we=%b required 1/0", done_cnt0 - dc, done_we0);
    end
    checks++;
    if (ovf0 !== 1'b1) begin
      errors++; $display("FAIL clip_overflow got %b required 1", ovf0);
    end
    @(posedge Clk); #1;
    start0 = 1'b1; base0 = 13'd0;
    @(posedge Clk); #1;
    start0 = 1'b0;
    @(negedge Clk);
    checks++;
    if (ovf0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL clip_restart got ovf=%b busy=%b required 0/1", ovf0, busy0);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic test_start_ignored_reset;
    int unsigned wr;
    bit to1, to2;
    wr = writes0;
    stream(1'b0, 1'b1, 13'd0, 0, 500, 1'b0, 1'b0, to1);
    @(posedge Clk); #1;
    start0 = 1'b1; base0 = 13'd777;
    @(posedge Clk); #1;
    start0 = 1'b0;
    stream(1'b0, 1'b0, 13'd0, 500, 10, 1'b0, 1'b0, to2);
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({bus0.we, bus0.pixel_ready, busy0, done0, ovf0} !== 5'b0 ||
        bus0.write_address !== 13'd0 || bus0.write_data !== 24'd0) begin
      errors++;
      $display("FAIL midreset_outputs got flags=%b addr=%0d data=%h required 0/0/0",
               {bus0.we, bus0.pixel_ready, busy0, done0, ovf0}, bus0.write_address, bus0.write_data);
    end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (to1 || to2 || writes0 - wr != 510 || sb0.size() != 0) begin
      errors++;
      $display("FAIL midreset_writes got %0d pending=%0d timeout=%b required 510/0",
               writes0 - wr, sb0.size(), to1 | to2);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL midreset_idle got busy=%b required 0", busy0);
    end
  endtask

  task automatic test_transparent;
    int unsigned wr, dc, want;
    bit to;
    want = SKIP ? 800 : 1600;
    wr = writes0; dc = done_cnt0;
    stream(1'b0, 1'b1, 13'd0, 0, 1600, 1'b0, 1'b1, to);
    repeat (3) @(negedge Clk);
    checks++;
    if (to || writes0 - wr != want) begin
      errors++;
      $display("FAIL key_writes got %0d timeout=%b required %0d", writes0 - wr, to, want);
    end
    checks++;
    if (done_cnt0 - dc != 1 || done_addr0 !== 13'd1599 || done_we0 !== 1'b1) begin
      errors++;
      $display("FAIL key_done got done=%0d addr=%0d we=%b required 1/1599/1",
               done_cnt0 - dc, done_addr0, done_we0);
    end
    checks++;
    if (sb0.size() != 0) begin
      errors++; $display("FAIL key_pending got %0d required 0", sb0.size());
    end
  endtask

  initial begin
    bus0.pixel_in = '0; bus0.pixel_valid = 1'b0;
    bus1.pixel_in = '0; bus1.pixel_valid = 1'b0;
    test_reset();
    test_full_fill();
    test_gaps();
    test_small_window();
    test_clip();
    test_start_ignored_reset();
    test_transparent();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_ram_writer.md
Name: sprite_ram_writer

Overview:
- Streaming writer that fills a sprite/frame RAM from a pixel stream, e.g. a UART loader or a procedural note-sprite generator.
- Accepts 24-bit RGB pixels over a valid/ready handshake.
- Generates row/column-ordered write addresses into a rectangular window of a flat RAM.
- Drives a registered write port. Sits between the pixel source and the write side of the sprite memories that the display readers consume.

Parameters:
- DATA_W, 24, pixel width (RGB888).
- ADDR_W, 13, RAM address width.
- MEM_DEPTH, 1600, number of valid RAM entries; addresses >= MEM_DEPTH are never written.
- SPRITE_W, 40, window width in pixels.
- SPRITE_H, 40, window height in pixels.
- STRIDE, 40, RAM words per row; must be >= SPRITE_W.
- KEY_COLOR, 24'hFF00FF, transparency key (used only with the optional feature).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a window fill
- base_address  in  ADDR_W  RAM address of window pixel (0,0); sampled on accepted start
- pixel_in  in  DATA_W  stream pixel
- pixel_valid  in  1  pixel_in valid
- pixel_ready  out  1  writer accepts pixel this cycle
- we  out  1  RAM write enable (registered)
- write_address  out  ADDR_W  RAM write address (registered)
- write_data  out  DATA_W  RAM write data (registered)
- busy  out  1  high in WRITE and DONE
- done  out  1  one-cycle pulse at fill completion
- overflow  out  1  sticky; a window address reached >= MEM_DEPTH

Behaviour:
- Reset (Reset_n=0 at a Clk edge): state=IDLE, col=row=0, pixel_ready=0, we=0, write_address=0, write_data=0, busy=0, done=0, overflow=0. Reset mid-fill abandons the window; no further writes occur.
- Handshake: a transfer occurs when pixel_valid && pixel_ready at a Clk edge. pixel_ready=1 only in WRITE. The source may hold pixel_valid low indefinitely; the counters stall.
- States:
  - IDLE: start=1 -> WRITE. Latch base_address; col=row=0; clear overflow.
  - WRITE: on each transfer, col++. If col==SPRITE_W-1: col=0, row++. A transfer with col==SPRITE_W-1 and row==SPRITE_H-1 -> DONE.
  - DONE: done=1 for exactly this cycle; pixel_ready=0; unconditionally -> IDLE next edge.
- start is ignored outside IDLE.
- Address: addr = base + row*STRIDE + col, computed at ADDR_W+1 bits; no wrap-around.
- Write latency: a transfer at edge N produces we=1, write_address=addr, write_data=pixel_in during cycle N+1. we=0 in every cycle with no transfer in the previous cycle. The last write coincides with done=1.
- Clipping: if addr >= MEM_DEPTH (including ADDR_W overflow), we stays 0 for that pixel and overflow sets. The pixel is still consumed and the counters advance. overflow holds until the next accepted start or reset.
- busy = (state != IDLE).
- Total transfers per fill: exactly SPRITE_W*SPRITE_H (1600 at defaults).

Optional Feature:
- Macro: SPRITE_RAM_WRITER_TRANSPARENT_SKIP_EN
- Defined: a transferred pixel equal to KEY_COLOR is consumed and the counters advance, but we=0 for that slot. This preserves the existing RAM content (background) underneath.
- Undefined: every in-range pixel is written, KEY_COLOR included. The KEY_COLOR parameter is unused.

Decomposition:
- Package sprite_pkg:
  - pixel_t (logic [23:0]), addr_t (logic [12:0])
  - writer_state_t enum {IDLE, WRITE, DONE}
  - constants SPRITE_DIM=40, SPRITE_WORDS=1600
- Sub-module sprite_addr_gen holds col/row counters, the base register, the address adder and the range compare. Inputs: clear, advance. Outputs: addr, in_range, last.
- The top module holds the FSM, handshake and output registers.

Test Plan:
- Reset, then start with base_address=0 and 1600 pixels (pixel_in = index), valid held high -> we pulses 1600 consecutive cycles, address k carries data k, done=1 with write_address=1599, overflow=0.
- Fill with pixel_valid toggling 1-0 every cycle -> exactly 1600 writes, gaps with we=0, same address/data pairs; busy high throughout.
- SPRITE_W=4, SPRITE_H=2, STRIDE=40, base 100 -> writes to 100,101,102,103,140,141,142,143, then done.
- base_address=1590 at defaults -> addresses 1590..1599 written, all later pixels consumed with we=0, overflow=1 at done, cleared by next start.
- Start pulse in WRITE, and Reset_n=0 after 500 transfers -> start ignored; after reset state=IDLE, no we, outputs at reset values; a new fill is accepted normally.
- With SPRITE_RAM_WRITER_TRANSPARENT_SKIP_EN, stream alternating 24'hFF00FF / 24'h00FF00 -> only odd-index addresses written, 1600 transfers, done on schedule; without the macro, all 1600 written.
